// File: rtl/ysyx_22050019_lsu.sv
// MEM-stage load/store unit: IDLE->REQ->WAIT->DONE bus access, stalls EX/MEM until DONE.
// Define LSU_MISALIGN_CHK_EN to trap misaligned H/W/D accesses straight to DONE without a bus request.
module ysyx_22050019_lsu #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          ram_we_i,
  input  logic [DW-1:0] ram_wdata_i,
  input  logic [3:0]    mem_w_wdth_i,
  input  logic          ram_re_i,
  input  logic [5:0]    mem_r_wdth_i,
  output logic          lsu_stall_o,
  output logic [DW-1:0] load_data_o,
  output logic          load_valid_o,
  output logic          req_valid_o,
  input  logic          req_ready_i,
  output logic          req_we_o,
  output logic [AW-1:0] req_addr_o,
  output logic [DW-1:0] req_wdata_o,
  output logic [7:0]    req_wstrb_o,
  input  logic          rsp_valid_i,
  input  logic [DW-1:0] rsp_rdata_i,
  output logic          misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e        state_q;
  logic          req_valid_q, req_we_q, load_valid_q, is_load_q, ld_zext_q;
  logic [AW-1:0] req_addr_q;
  logic [DW-1:0] req_wdata_q, load_data_q;
  logic [7:0]    req_wstrb_q;
  logic [1:0]    ld_sz_q;

  logic          access, is_load;
  logic [1:0]    sz;
  logic [2:0]    off;
  logic [7:0]    strb_base, req_wstrb_d;
  logic [DW-1:0] req_wdata_d, beat, load_data_d;
  logic          unused_ok;

  // Size code 0=B 1=H 2=W 3=D; anything not exactly one-hot is treated as D.
  function automatic logic [1:0] size_code(input logic [3:0] oh);
    case (oh)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  assign access    = ram_re_i | ram_we_i;
  assign is_load   = ram_re_i;
  assign sz        = is_load ? size_code(mem_r_wdth_i[3:0]) : size_code(mem_w_wdth_i);
  assign off       = addr_i[2:0];
  assign unused_ok = &{1'b0, mem_r_wdth_i[5]};

  always_comb begin
    case (sz)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  assign req_wstrb_d = is_load ? 8'h00 : (strb_base << off);
  assign req_wdata_d = is_load ? '0 : (ram_wdata_i << {off, 3'b000});

  assign beat = rsp_rdata_i >> {req_addr_q[2:0], 3'b000};

  always_comb begin
    case (ld_sz_q)
      2'd0:    load_data_d = ld_zext_q ? {56'b0, beat[7:0]}  : {{56{beat[7]}},  beat[7:0]};
      2'd1:    load_data_d = ld_zext_q ? {48'b0, beat[15:0]} : {{48{beat[15]}}, beat[15:0]};
      2'd2:    load_data_d = ld_zext_q ? {32'b0, beat[31:0]} : {{32{beat[31]}}, beat[31:0]};
      default: load_data_d = beat;
    endcase
  end

`ifdef LSU_MISALIGN_CHK_EN
  logic misalign_q, misaligned;
  assign misaligned = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off[1:0] != 2'b00) ||
                      (sz == 2'd3 && off != 3'b000);
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wstrb_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      is_load_q    <= 1'b0;
      ld_sz_q      <= 2'd0;
      ld_zext_q    <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
`ifdef LSU_MISALIGN_CHK_EN
            if (misaligned) begin
              state_q    <= DONE;
              misalign_q <= 1'b1;
            end else begin
`else
            begin
`endif
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_we_q    <= ~is_load;
              req_addr_q  <= addr_i;
              req_wdata_q <= req_wdata_d;
              req_wstrb_q <= req_wstrb_d;
              is_load_q   <= is_load;
              ld_sz_q     <= sz;
              ld_zext_q   <= mem_r_wdth_i[4];
            end
          end
        end
        REQ: begin
          if (req_ready_i) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (rsp_valid_i) begin
            state_q <= DONE;
            if (is_load_q) begin
              load_data_q  <= load_data_d;
              load_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          load_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
          misalign_q   <= 1'b0;
`endif
        end
      endcase
    end
  end

  // Combinational so the hazard unit freezes EX/MEM in the same cycle the access is seen.
  assign lsu_stall_o  = (state_q == IDLE && access) || state_q == REQ || state_q == WAIT;
  assign req_valid_o  = req_valid_q;
  assign req_we_o     = req_we_q;
  assign req_addr_o   = req_addr_q;
  assign req_wdata_o  = req_wdata_q;
  assign req_wstrb_o  = req_wstrb_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;

endmodule
